// File: rtl/ariane_pkg.sv
// Shared types for the scoreboard slice.
//   NR_SB_ENTRIES    : default number of scoreboard slots
//   TRANS_ID_BITS    : width of a slot index / transaction ID
//   fu_t             : functional unit selector
//   exception        : exception record carried with an instruction
//   scoreboard_entry : one in-flight instruction as held in the scoreboard
package ariane_pkg;

    localparam int NR_SB_ENTRIES = 8;
    localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef enum logic [1:0] {
        ALU  = 2'd0,
        MULT = 2'd1,
        LSU  = 2'd2,
        CSR  = 2'd3
    } fu_t;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception;

    typedef struct packed {
        logic [63:0] pc;
        fu_t         fu;
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] result;
        logic        valid;    // result has been written back
        exception    ex;
    } scoreboard_entry;

endpackage

// File: rtl/sb_operand_lookup.sv
// Youngest-match operand lookup for one source register.
// Only defined when SB_FORWARD_EN is set.
//   rs_i        : source register being looked up (x0 never matches)
//   issue_ptr_i : current issue pointer; the youngest issued slot sits just behind it
//   live_i      : per-slot occupied & issued
//   done_i      : per-slot result written back
//   rd_i        : per-slot destination register
//   result_i    : per-slot result value
//   value_o     : forwarded value (zero unless valid_o)
//   valid_o     : youngest matching slot has its result
`ifdef SB_FORWARD_EN
module sb_operand_lookup #(
    parameter int NR_ENTRIES    = 8,
    parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic [4:0]                   rs_i,
    input  logic [TRANS_ID_BITS-1:0]     issue_ptr_i,
    input  logic [NR_ENTRIES-1:0]        live_i,
    input  logic [NR_ENTRIES-1:0]        done_i,
    input  logic [NR_ENTRIES-1:0][4:0]   rd_i,
    input  logic [NR_ENTRIES-1:0][63:0]  result_i,
    output logic [63:0]                  value_o,
    output logic                         valid_o
);

    // Walk backwards from the issue pointer; the first live match is the
    // youngest writer of rs_i and hides any older writers.
    always_comb begin
        logic                     found;
        logic [TRANS_ID_BITS-1:0] idx;
        found   = 1'b0;
        idx     = '0;
        value_o = '0;
        valid_o = 1'b0;
        for (int k = 1; k <= NR_ENTRIES; k++) begin
            idx = issue_ptr_i - TRANS_ID_BITS'(k);
            if (!found && rs_i != 5'd0 && live_i[idx] && rd_i[idx] == rs_i) begin
                found   = 1'b1;
                valid_o = done_i[idx];
                value_o = done_i[idx] ? result_i[idx] : '0;
            end
        end
    end

endmodule
`endif

// File: rtl/scoreboard.sv
// In-order scoreboard: accepts decoded instructions into a circular buffer,
// hands them out in order for issue, collects out-of-order writebacks by
// transaction ID and releases them in order to commit. Reports pending
// destination registers and, optionally, forwards completed results.
//
// Configuration macro: SB_FORWARD_EN
//   defined   : rs1_o/rs2_o forward the youngest completed result
//   undefined : no lookup logic, rs*_o/rs*_valid_o tied to 0, and issue
//               stalls while either source register is clobbered
//
// Ports:
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   flush_i                : synchronous discard of all entries
//   full_o                 : no free slot
//   decoded_instr_*        : instruction intake and acceptance
//   issue_*                : oldest not-yet-issued entry and its handshake
//   rs1_i/rs2_i, rs*_o     : operand forwarding lookup
//   rd_clobber_o           : per-register pending-write flags
//   trans_id_i, wdata_i, wb_valid_i, ex_i : writeback
//   commit_*               : oldest entry and its handshake
module scoreboard import ariane_pkg::*; #(
    parameter int NR_ENTRIES    = NR_SB_ENTRIES,
    parameter int TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    output logic                      full_o,
    input  scoreboard_entry           decoded_instr_i,
    input  logic                      decoded_instr_valid_i,
    output logic                      decoded_instr_ack_o,
    output scoreboard_entry           issue_instr_o,
    output logic [TRANS_ID_BITS-1:0]  issue_trans_id_o,
    output logic                      issue_instr_valid_o,
    input  logic                      issue_ack_i,
    input  logic [4:0]                rs1_i,
    input  logic [4:0]                rs2_i,
    output logic [63:0]               rs1_o,
    output logic                      rs1_valid_o,
    output logic [63:0]               rs2_o,
    output logic                      rs2_valid_o,
    output logic [31:0]               rd_clobber_o,
    input  logic [TRANS_ID_BITS-1:0]  trans_id_i,
    input  logic [63:0]               wdata_i,
    input  logic                      wb_valid_i,
    input  exception                  ex_i,
    output scoreboard_entry           commit_instr_o,
    output logic                      commit_valid_o,
    input  logic                      commit_ack_i
);

    localparam int CNT_BITS = TRANS_ID_BITS + 1;

    scoreboard_entry               mem_q [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]         occupied_q;
    logic [NR_ENTRIES-1:0]         issued_q;
    logic [TRANS_ID_BITS-1:0]      tail_q;
    logic [TRANS_ID_BITS-1:0]      issue_ptr_q;
    logic [TRANS_ID_BITS-1:0]      commit_ptr_q;
    logic [CNT_BITS-1:0]           count_q;
    logic [CNT_BITS-1:0]           count_n;
    logic                          full_q;

    logic                          accept;
    logic                          issue_valid;
    logic                          issue_fire;
    logic                          commit_valid;
    logic                          commit_fire;
    logic                          wb_ok;
    logic                          stall;
    logic [NR_ENTRIES-1:0]         live;
    logic [NR_ENTRIES-1:0][4:0]    slot_rd;
    logic [31:0]                   clobber;

    // Flush overrides every handshake in its cycle.
    assign accept       = decoded_instr_valid_i & ~full_q & ~flush_i;
    assign issue_valid  = occupied_q[issue_ptr_q] & ~issued_q[issue_ptr_q] & ~stall;
    assign issue_fire   = issue_ack_i & issue_valid & ~flush_i;
    // Commit looks only at the registered .valid, so a same-cycle writeback
    // of the oldest slot commits one cycle later.
    assign commit_valid = occupied_q[commit_ptr_q] & issued_q[commit_ptr_q] & mem_q[commit_ptr_q].valid;
    assign commit_fire  = commit_ack_i & commit_valid & ~flush_i;
    assign wb_ok        = wb_valid_i & ~flush_i & occupied_q[trans_id_i] & issued_q[trans_id_i];
    assign count_n      = count_q + CNT_BITS'(accept) - CNT_BITS'(commit_fire);

    assign full_o              = full_q;
    assign decoded_instr_ack_o = accept;
    assign issue_instr_valid_o = issue_valid;
    assign issue_instr_o       = issue_valid ? mem_q[issue_ptr_q] : '0;
    assign issue_trans_id_o    = issue_ptr_q;
    assign commit_valid_o      = commit_valid;
    assign commit_instr_o      = occupied_q[commit_ptr_q] ? mem_q[commit_ptr_q] : '0;
    assign rd_clobber_o        = clobber;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occupied_q   <= '0;
            issued_q     <= '0;
            tail_q       <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
        end else if (flush_i) begin
            occupied_q   <= '0;
            issued_q     <= '0;
            tail_q       <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
        end else begin
            // accept, issue and commit always touch three different slots
            if (accept) begin
                occupied_q[tail_q] <= 1'b1;
                issued_q[tail_q]   <= 1'b0;
                tail_q             <= tail_q + TRANS_ID_BITS'(1);
            end
            if (issue_fire) begin
                issued_q[issue_ptr_q] <= 1'b1;
                issue_ptr_q           <= issue_ptr_q + TRANS_ID_BITS'(1);
            end
            if (commit_fire) begin
                occupied_q[commit_ptr_q] <= 1'b0;
                issued_q[commit_ptr_q]   <= 1'b0;
                commit_ptr_q             <= commit_ptr_q + TRANS_ID_BITS'(1);
            end
            count_q <= count_n;
            full_q  <= (count_n == CNT_BITS'(NR_ENTRIES));
        end
    end

    // NOTE: the payload array has no reset; occupied/issued qualify every use
    // of it, so resetting it would only add fan-out to rst_i.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mem_q[tail_q]          <= decoded_instr_i;
            mem_q[tail_q].valid    <= 1'b0;
            mem_q[tail_q].ex.valid <= 1'b0;
        end
        if (wb_ok) begin
            mem_q[trans_id_i].result <= wdata_i;
            mem_q[trans_id_i].valid  <= 1'b1;
            if (ex_i.valid) begin
                mem_q[trans_id_i].ex <= ex_i;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            live[i]    = occupied_q[i] & issued_q[i];
            slot_rd[i] = mem_q[i].rd;
        end
    end

    // NOTE: default first so no path through the loop can leave a bit
    // unassigned and infer a latch.
    always_comb begin
        clobber = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (live[i]) begin
                clobber[slot_rd[i]] = 1'b1;
            end
        end
        clobber[0] = 1'b0;
    end

`ifdef SB_FORWARD_EN
    logic [NR_ENTRIES-1:0]        done;
    logic [NR_ENTRIES-1:0][63:0]  slot_result;

    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            done[i]        = mem_q[i].valid;
            slot_result[i] = mem_q[i].result;
        end
    end

    sb_operand_lookup #(
        .NR_ENTRIES    (NR_ENTRIES),
        .TRANS_ID_BITS (TRANS_ID_BITS)
    ) i_rs1_lookup (
        .rs_i        (rs1_i),
        .issue_ptr_i (issue_ptr_q),
        .live_i      (live),
        .done_i      (done),
        .rd_i        (slot_rd),
        .result_i    (slot_result),
        .value_o     (rs1_o),
        .valid_o     (rs1_valid_o)
    );

    sb_operand_lookup #(
        .NR_ENTRIES    (NR_ENTRIES),
        .TRANS_ID_BITS (TRANS_ID_BITS)
    ) i_rs2_lookup (
        .rs_i        (rs2_i),
        .issue_ptr_i (issue_ptr_q),
        .live_i      (live),
        .done_i      (done),
        .rd_i        (slot_rd),
        .result_i    (slot_result),
        .value_o     (rs2_o),
        .valid_o     (rs2_valid_o)
    );

    assign stall = 1'b0;
`else
    assign rs1_o       = '0;
    assign rs1_valid_o = 1'b0;
    assign rs2_o       = '0;
    assign rs2_valid_o = 1'b0;
    // Without forwarding a reader must wait until its producer has committed.
    assign stall = clobber[mem_q[issue_ptr_q].rs1] | clobber[mem_q[issue_ptr_q].rs2];
`endif

    // A writeback may only target an in-flight, issued slot.
    wb_to_issued_slot: assert property (@(posedge clk_i) disable iff (rst_i)
        (wb_valid_i && !flush_i) |-> (occupied_q[trans_id_i] && issued_q[trans_id_i]));

endmodule

// File: tb/tb_scoreboard.sv
`timescale 1ns/1ps
module tb_scoreboard;
    import ariane_pkg::*;

    localparam int N = NR_SB_ENTRIES;

    logic                      clk_i = 1'b0;
    logic                      rst_i;
    logic                      flush_i;
    logic                      full_o;
    scoreboard_entry           decoded_instr_i;
    logic                      decoded_instr_valid_i;
    logic                      decoded_instr_ack_o;
    scoreboard_entry           issue_instr_o;
    logic [TRANS_ID_BITS-1:0]  issue_trans_id_o;
    logic                      issue_instr_valid_o;
    logic                      issue_ack_i;
    logic [4:0]                rs1_i;
    logic [4:0]                rs2_i;
    logic [63:0]               rs1_o;
    logic                      rs1_valid_o;
    logic [63:0]               rs2_o;
    logic                      rs2_valid_o;
    logic [31:0]               rd_clobber_o;
    logic [TRANS_ID_BITS-1:0]  trans_id_i;
    logic [63:0]               wdata_i;
    logic                      wb_valid_i;
    exception                  ex_i;
    scoreboard_entry           commit_instr_o;
    logic                      commit_valid_o;
    logic                      commit_ack_i;

    always #5 clk_i = ~clk_i;

    scoreboard #(.NR_ENTRIES(N)) dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .flush_i               (flush_i),
        .full_o                (full_o),
        .decoded_instr_i       (decoded_instr_i),
        .decoded_instr_valid_i (decoded_instr_valid_i),
        .decoded_instr_ack_o   (decoded_instr_ack_o),
        .issue_instr_o         (issue_instr_o),
        .issue_trans_id_o      (issue_trans_id_o),
        .issue_instr_valid_o   (issue_instr_valid_o),
        .issue_ack_i           (issue_ack_i),
        .rs1_i                 (rs1_i),
        .rs2_i                 (rs2_i),
        .rs1_o                 (rs1_o),
        .rs1_valid_o           (rs1_valid_o),
        .rs2_o                 (rs2_o),
        .rs2_valid_o           (rs2_valid_o),
        .rd_clobber_o          (rd_clobber_o),
        .trans_id_i            (trans_id_i),
        .wdata_i               (wdata_i),
        .wb_valid_i            (wb_valid_i),
        .ex_i                  (ex_i),
        .commit_instr_o        (commit_instr_o),
        .commit_valid_o        (commit_valid_o),
        .commit_ack_i          (commit_ack_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: program-ordered list of in-flight instructions.
    typedef struct {
        scoreboard_entry e;
        int              slot;
        bit              issued;
    } rec_t;

    rec_t q[$];
    int   tail_cnt = 0;
    int   commits_seen = 0;
    int   next_commit_seq = 0;

    function automatic scoreboard_entry mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        scoreboard_entry e;
        e.pc       = {$urandom, $urandom};
        e.fu       = fu_t'($urandom_range(0, 3));
        e.op       = 7'($urandom);
        e.rs1      = rs1;
        e.rs2      = rs2;
        e.rd       = rd;
        e.result   = {$urandom, $urandom};
        e.valid    = 1'b1;            // must be cleared on accept
        e.ex.cause = {$urandom, $urandom};
        e.ex.tval  = {$urandom, $urandom};
        e.ex.valid = 1'b1;            // must be cleared on accept
        return e;
    endfunction

    task automatic clear_inputs();
        flush_i               = 1'b0;
        decoded_instr_valid_i = 1'b0;
        issue_ack_i           = 1'b0;
        wb_valid_i            = 1'b0;
        commit_ack_i          = 1'b0;
        rs1_i                 = 5'd0;
        rs2_i                 = 5'd0;
    endtask

    // Called at a falling edge with inputs already driven: checks outputs,
    // advances the model by one clock, then returns at the next falling edge.
    task automatic step();
        int              fi;
        bit              iv, cv, ack;
        bit              fv [2];
        logic [63:0]     fd [2];
        logic [4:0]      rs [2];
        logic [31:0]     clob;
        rec_t            t;
        #1;
        clob = '0;
        foreach (q[i]) if (q[i].issued) clob[q[i].e.rd] = 1'b1;
        clob[0] = 1'b0;
        fi = -1;
        foreach (q[i]) if (!q[i].issued && fi < 0) fi = i;
        iv = (fi >= 0);
`ifndef SB_FORWARD_EN
        if (iv) begin
            if (clob[q[fi].e.rs1] || clob[q[fi].e.rs2]) iv = 1'b0;
        end
`endif
        cv  = (q.size() > 0) && q[0].issued && q[0].e.valid;
        ack = decoded_instr_valid_i && (q.size() < N) && !flush_i;

        check("full", 512'(full_o), 512'(q.size() == N));
        check("ack", 512'(decoded_instr_ack_o), 512'(ack));
        check("issue_valid", 512'(issue_instr_valid_o), 512'(iv));
        if (iv) begin
            check("issue_trans_id", 512'(issue_trans_id_o), 512'(q[fi].slot));
            check("issue_instr", 512'(issue_instr_o), 512'(q[fi].e));
        end
        check("commit_valid", 512'(commit_valid_o), 512'(cv));
        if (cv) check("commit_instr", 512'(commit_instr_o), 512'(q[0].e));
        check("clobber", 512'(rd_clobber_o), 512'(clob));

        rs[0] = rs1_i;
        rs[1] = rs2_i;
        for (int j = 0; j < 2; j++) begin
            fv[j] = 1'b0;
            fd[j] = '0;
            if (rs[j] != 5'd0) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].issued && q[i].e.rd == rs[j]) begin
                        fv[j] = q[i].e.valid;
                        fd[j] = q[i].e.result;
                        break;
                    end
                end
            end
`ifndef SB_FORWARD_EN
            fv[j] = 1'b0;
            fd[j] = '0;
`endif
        end
        check("rs1_valid", 512'(rs1_valid_o), 512'(fv[0]));
        check("rs2_valid", 512'(rs2_valid_o), 512'(fv[1]));
`ifdef SB_FORWARD_EN
        if (fv[0]) check("rs1_data", 512'(rs1_o), 512'(fd[0]));
        if (fv[1]) check("rs2_data", 512'(rs2_o), 512'(fd[1]));
`else
        check("rs1_data", 512'(rs1_o), 512'(0));
        check("rs2_data", 512'(rs2_o), 512'(0));
`endif

        if (flush_i) begin
            q.delete();
            tail_cnt = 0;
            next_commit_seq = 0;
        end else begin
            if (issue_ack_i && iv) begin
                t = q[fi]; t.issued = 1'b1; q[fi] = t;
            end
            if (wb_valid_i) begin
                foreach (q[i]) begin
                    if (q[i].slot == int'(trans_id_i)) begin
                        t = q[i];
                        t.e.result = wdata_i;
                        t.e.valid  = 1'b1;
                        if (ex_i.valid) t.e.ex = ex_i;
                        q[i] = t;
                    end
                end
            end
            if (commit_ack_i && cv) begin
                check("commit_order", 512'(q[0].slot), 512'(next_commit_seq % N));
                void'(q.pop_front());
                next_commit_seq++;
                commits_seen++;
            end
            if (ack) begin
                t.e          = decoded_instr_i;
                t.e.valid    = 1'b0;
                t.e.ex.valid = 1'b0;
                t.slot       = tail_cnt % N;
                t.issued     = 1'b0;
                q.push_back(t);
                tail_cnt++;
            end
        end
        @(negedge clk_i);
        clear_inputs();
    endtask

    task automatic push(input logic [4:0] rd);
        decoded_instr_i       = mk(rd, 5'd0, 5'd0);
        decoded_instr_valid_i = 1'b1;
    endtask

    task automatic wb(input int slot, input logic [63:0] d);
        wb_valid_i = 1'b1;
        trans_id_i = TRANS_ID_BITS'(slot);
        wdata_i    = d;
        ex_i       = '0;
    endtask

    initial begin
        int cand [$];
        int c;
        rst_i           = 1'b1;
        decoded_instr_i = '0;
        trans_id_i      = '0;
        wdata_i         = '0;
        ex_i            = '0;
        clear_inputs();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("reset_issue_instr", 512'(issue_instr_o), 512'(0));
        check("reset_commit_instr", 512'(commit_instr_o), 512'(0));
        check("reset_rs1_o", 512'(rs1_o), 512'(0));
        check("reset_rs2_o", 512'(rs2_o), 512'(0));
        step();

        // Fill to full; the ninth offer is refused.
        for (int i = 0; i < 9; i++) begin push(5'(i + 1)); step(); end
        push(5'd9); step();
        flush_i = 1'b1; step();

        // Single producer, forwarded after writeback.
        push(5'd5); step();
        issue_ack_i = 1'b1; step();
        wb(0, 64'hDEAD); rs1_i = 5'd5; step();
        rs1_i = 5'd5; step();
        commit_ack_i = 1'b1; rs1_i = 5'd5; step();
        step();

        // Two writers of x3: the younger one hides the older result.
        push(5'd3); step();
        push(5'd3); issue_ack_i = 1'b1; step();
        issue_ack_i = 1'b1; step();
        wb(1, 64'h11); step();
        rs2_i = 5'd3; step();
        wb(2, 64'h22); step();
        rs2_i = 5'd3; commit_ack_i = 1'b1; step();
        commit_ack_i = 1'b1; step();
        flush_i = 1'b1; step();

        // Out-of-order writebacks, in-order commits.
        for (int i = 0; i < 3; i++) begin push(5'(10 + i)); issue_ack_i = 1'b1; step(); end
        issue_ack_i = 1'b1; step();
        wb(2, 64'h2); commit_ack_i = 1'b1; step();
        wb(0, 64'h0); commit_ack_i = 1'b1; step();
        wb(1, 64'h1); commit_ack_i = 1'b1; step();
        for (int i = 0; i < 4; i++) begin commit_ack_i = 1'b1; step(); end
        flush_i = 1'b1; step();

        // Full with simultaneous commit and offer: no accept that cycle.
        for (int i = 0; i < N; i++) begin push(5'(i + 1)); issue_ack_i = 1'b1; step(); end
        issue_ack_i = 1'b1; step();
        wb(0, 64'hA0); step();
        commit_ack_i = 1'b1; push(5'd20); step();
        push(5'd20); step();
        step();

        // Flush overrides a simultaneous push and writeback.
        flush_i = 1'b1; step();
        for (int i = 0; i < 4; i++) begin push(5'(i + 1)); issue_ack_i = (i < 2); step(); end
        flush_i = 1'b1; push(5'd7); wb(0, 64'h77); step();
        push(5'd8); step();
        step();
        flush_i = 1'b1; step();

        // Randomized traffic, wrapping the buffer many times.
        for (int n = 0; n < 3000; n++) begin
            decoded_instr_i       = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            decoded_instr_valid_i = ($urandom_range(0, 99) < 60);
            issue_ack_i           = ($urandom_range(0, 1) == 1);
            commit_ack_i          = ($urandom_range(0, 1) == 1);
            flush_i               = ($urandom_range(0, 99) < 2);
            rs1_i                 = 5'($urandom_range(0, 7));
            rs2_i                 = 5'($urandom_range(0, 7));
            cand.delete();
            foreach (q[i]) if (q[i].issued && !q[i].e.valid) cand.push_back(q[i].slot);
            if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                c = cand[$urandom_range(0, cand.size() - 1)];
                wb(c, {$urandom, $urandom});
                ex_i.cause = {$urandom, $urandom};
                ex_i.tval  = {$urandom, $urandom};
                ex_i.valid = ($urandom_range(0, 7) == 0);
            end
            step();
        end

        check("random_commits_progressed", 512'(commits_seen > 100), 512'(1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
